// File: rtl/ictrl_ibuf_pkg.sv
// Shared definitions for the multi-reader ibuffer arbiter.
//   state_e   : phase encoding that appears on the top-level 'phase' output
//   tag_width : width of an index/tag for n items, never less than 1 bit
package ictrl_ibuf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DMA_WR = 2'd1,
    NOC_RD = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ictrl_rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointer returns to 0)
//   req  [N]   : request vector
//   en         : grant enable; with en=0 no grant is produced
//   adv        : the current grant was accepted; pointer moves past it
//   gnt  [N]   : one-hot grant (combinational from req/pointer)
//   idx        : index of the granted requester
module ictrl_rr_arbiter
  import ictrl_ibuf_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = tag_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] k;
  logic          found;

  // Scan requesters starting at the pointer; the first one found wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/ictrl_ibuffer_arbiter_mc.sv
// Phase-switches the ibuffer between one DMA write port and NUM_RD NoC read
// ports (round-robin among readers). Outstanding read tags are kept in an
// inline FIFO so in-order ibuffer responses are routed to the issuing reader.
// Optional feature macro: ICTRL_IBUF_ARB_PERF_EN adds perf_clr, perf_rd_cnt
// (accepted reads) and perf_stall_cnt (requesting-but-not-accepted cycles).
// Ports:
//   dma_read_start/dma_write_done : phase control pulses
//   dma_wr_*   : DMA write port, passed to the ibuffer in DMA_WR
//   noc_rd_*   : NUM_RD read channels, addresses packed ch0 in LSBs
//   ibuffer_*  : ibuffer request/response interface
//   phase      : current state, rsp_err : sticky orphan-response flag
//
// state  | meaning
// IDLE   | after reset, waits for the first DMA start
// DMA_WR | DMA owns the ibuffer, stray responses are discarded
// NOC_RD | readers arbitrated round-robin, responses routed by tag
// DRAIN  | no new grants, wait for outstanding responses, then DMA_WR
module ictrl_ibuffer_arbiter_mc
  import ictrl_ibuf_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_RD     = 4,
  parameter int OST_DEPTH  = 4,
  localparam int ID_W      = tag_width(NUM_RD)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dma_read_start,
  input  logic                     dma_write_done,
  input  logic                     dma_wr_cen,
  input  logic                     dma_wr_wen,
  output logic                     dma_wr_ready,
  input  logic [MEM_AW-1:0]        dma_wr_addr,
  input  logic [DATA_WIDTH-1:0]    dma_wr_wdata,
  input  logic [STRB_WIDTH-1:0]    dma_wr_strb,
  input  logic [NUM_RD-1:0]        noc_rd_cen,
  output logic [NUM_RD-1:0]        noc_rd_ready,
  input  logic [NUM_RD*MEM_AW-1:0] noc_rd_addr,
  output logic [DATA_WIDTH-1:0]    noc_rd_rdata,
  output logic [NUM_RD-1:0]        noc_rd_rvalid,
  input  logic [NUM_RD-1:0]        noc_rd_rready,
  output logic                     ibuffer_cen,
  output logic                     ibuffer_wen,
  input  logic                     ibuffer_ready,
  output logic [MEM_AW-1:0]        ibuffer_addr,
  output logic [DATA_WIDTH-1:0]    ibuffer_wdata,
  output logic [STRB_WIDTH-1:0]    ibuffer_strb,
  input  logic [DATA_WIDTH-1:0]    ibuffer_rdata,
  input  logic                     ibuffer_rvalid,
  output logic                     ibuffer_rready,
  output logic [1:0]               phase,
`ifdef ICTRL_IBUF_ARB_PERF_EN
  input  logic                     perf_clr,
  output logic [31:0]              perf_rd_cnt,
  output logic [31:0]              perf_stall_cnt,
`endif
  output logic                     rsp_err
);

  localparam int PW = tag_width(OST_DEPTH);

  state_e state, state_nxt;

  logic [ID_W-1:0] tag_q [OST_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, empty, push, pop, rsp_phase;
  logic [ID_W-1:0] head;
  logic [NUM_RD-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;

  assign full      = (count == (PW + 1)'(OST_DEPTH));
  assign empty     = (count == '0);
  assign head      = tag_q[rd_ptr];
  assign rsp_phase = (state == NOC_RD) || (state == DRAIN);
  assign push      = (state == NOC_RD) && ibuffer_cen && ibuffer_ready;
  assign pop       = rsp_phase && !empty && ibuffer_rvalid && ibuffer_rready;
  assign phase     = state;
  assign noc_rd_rdata = ibuffer_rdata;

  // Grants are gated by !full alone, so a same-cycle pop never frees a slot.
  ictrl_rr_arbiter #(.N(NUM_RD)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (noc_rd_cen),
    .en    ((state == NOC_RD) && !full),
    .adv   (push),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    dma_wr_ready   = 1'b0;
    noc_rd_ready   = '0;
    noc_rd_rvalid  = '0;
    ibuffer_cen    = 1'b0;
    ibuffer_wen    = 1'b0;
    ibuffer_addr   = dma_wr_addr;
    ibuffer_wdata  = dma_wr_wdata;
    ibuffer_strb   = dma_wr_strb;
    ibuffer_rready = 1'b0;
    case (state)
      IDLE: begin
        if (dma_read_start) state_nxt = DMA_WR;
      end
      DMA_WR: begin
        ibuffer_cen    = dma_wr_cen;
        ibuffer_wen    = dma_wr_wen;
        dma_wr_ready   = ibuffer_ready;
        ibuffer_rready = 1'b1;
        if (dma_write_done) state_nxt = NOC_RD;
      end
      NOC_RD: begin
        ibuffer_cen  = |gnt;
        ibuffer_addr = noc_rd_addr[gnt_idx*MEM_AW +: MEM_AW];
        noc_rd_ready = gnt & {NUM_RD{ibuffer_ready}};
        if (dma_read_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (empty) state_nxt = DMA_WR;
      end
      default: state_nxt = IDLE;
    endcase
    // Orphan responses are always accepted so the ibuffer cannot stall.
    if (rsp_phase) begin
      if (empty) begin
        ibuffer_rready = 1'b1;
      end else begin
        noc_rd_rvalid[head] = ibuffer_rvalid;
        ibuffer_rready      = noc_rd_rready[head];
      end
    end
  end

  // Tag storage carries no reset: entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(OST_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(OST_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
      if (rsp_phase && ibuffer_rvalid && empty) rsp_err <= 1'b1;
    end
  end

`ifdef ICTRL_IBUF_ARB_PERF_EN
  logic stall;
  assign stall = (state == NOC_RD) && (|noc_rd_cen) && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_rd_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && (perf_rd_cnt != '1))     perf_rd_cnt    <= perf_rd_cnt + 32'd1;
      if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ictrl_ibuffer_arbiter_mc.sv
module tb_ictrl_ibuffer_arbiter_mc;

  localparam int DW = 128;
  localparam int AW = 15;
  localparam int SW = DW / 8;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           dma_read_start, dma_write_done;
  logic           dma_wr_cen, dma_wr_wen, dma_wr_ready;
  logic [AW-1:0]  dma_wr_addr;
  logic [DW-1:0]  dma_wr_wdata;
  logic [SW-1:0]  dma_wr_strb;
  logic [NR-1:0]  noc_rd_cen, noc_rd_ready, noc_rd_rvalid, noc_rd_rready;
  logic [NR*AW-1:0] noc_rd_addr;
  logic [DW-1:0]  noc_rd_rdata;
  logic           ibuffer_cen, ibuffer_wen, ibuffer_ready;
  logic [AW-1:0]  ibuffer_addr;
  logic [DW-1:0]  ibuffer_wdata, ibuffer_rdata;
  logic [SW-1:0]  ibuffer_strb;
  logic           ibuffer_rvalid, ibuffer_rready;
  logic [1:0]     phase;
  logic           rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ictrl_ibuffer_arbiter_mc dut (
    .clk(clk), .rst_n(rst_n),
    .dma_read_start(dma_read_start), .dma_write_done(dma_write_done),
    .dma_wr_cen(dma_wr_cen), .dma_wr_wen(dma_wr_wen), .dma_wr_ready(dma_wr_ready),
    .dma_wr_addr(dma_wr_addr), .dma_wr_wdata(dma_wr_wdata), .dma_wr_strb(dma_wr_strb),
    .noc_rd_cen(noc_rd_cen), .noc_rd_ready(noc_rd_ready), .noc_rd_addr(noc_rd_addr),
    .noc_rd_rdata(noc_rd_rdata), .noc_rd_rvalid(noc_rd_rvalid), .noc_rd_rready(noc_rd_rready),
    .ibuffer_cen(ibuffer_cen), .ibuffer_wen(ibuffer_wen), .ibuffer_ready(ibuffer_ready),
    .ibuffer_addr(ibuffer_addr), .ibuffer_wdata(ibuffer_wdata), .ibuffer_strb(ibuffer_strb),
    .ibuffer_rdata(ibuffer_rdata), .ibuffer_rvalid(ibuffer_rvalid), .ibuffer_rready(ibuffer_rready),
    .phase(phase), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    dma_read_start = 0; dma_write_done = 0;
    dma_wr_cen = 0; dma_wr_wen = 0; dma_wr_addr = '0; dma_wr_wdata = '0; dma_wr_strb = '0;
    noc_rd_cen = '0; noc_rd_rready = '0;
    ibuffer_ready = 0; ibuffer_rdata = '0; ibuffer_rvalid = 0;
    for (int k = 0; k < NR; k++) noc_rd_addr[k*AW +: AW] = AW'(16'h100 + k);
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_dma_ready", dma_wr_ready, 0);
    chk("rst_noc_ready", noc_rd_ready, 0);
    chk("rst_rvalid", noc_rd_rvalid, 0);
    chk("rst_cen", ibuffer_cen, 0);
    chk("rst_err", rsp_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: DMA write phase
    dma_read_start = 1; #1;
    chk("t1_idle", phase, 0);
    tick();
    dma_read_start = 0; #1;
    chk("t1_dmawr", phase, 1);
    for (int i = 0; i < 8; i++) begin
      dma_wr_cen = 1; dma_wr_wen = 1; dma_wr_addr = AW'(i + 3);
      dma_wr_wdata = DW'(i * 7 + 1); dma_wr_strb = '1; ibuffer_ready = 1; noc_rd_cen = 4'hF;
      #1;
      chk("t1_cen", ibuffer_cen, 1);
      chk("t1_wen", ibuffer_wen, 1);
      chk("t1_addr", ibuffer_addr, DW'(i + 3));
      chk("t1_wdata", ibuffer_wdata, DW'(i * 7 + 1));
      chk("t1_dma_ready", dma_wr_ready, 1);
      chk("t1_no_noc_ready", noc_rd_ready, 0);
      tick();
    end
    dma_wr_cen = 0; dma_wr_wen = 0; dma_write_done = 1; #1;
    chk("t1_before_done", phase, 1);
    tick();
    dma_write_done = 0; #1;
    chk("t1_nocrd", phase, 2);

    // 2: round-robin with one read in flight per cycle
    noc_rd_rready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      noc_rd_cen = 4'hF; ibuffer_ready = 1; ibuffer_rvalid = (i > 0);
      ibuffer_rdata = DW'(32'hA0 + i);
      #1;
      chk("t2_grant", noc_rd_ready, DW'(1 << (i % 4)));
      chk("t2_addr", ibuffer_addr, DW'(16'h100 + (i % 4)));
      chk("t2_wen", ibuffer_wen, 0);
      chk("t2_rvalid", noc_rd_rvalid, (i == 0) ? DW'(0) : DW'(1 << ((i - 1) % 4)));
      chk("t2_rdata", noc_rd_rdata, DW'(32'hA0 + i));
      tick();
    end
    noc_rd_cen = 0; ibuffer_rvalid = 1; #1;
    chk("t2_last_rvalid", noc_rd_rvalid, 4'b0001);
    tick();

    // 3: fill the tag FIFO (pointer now at ch1)
    ibuffer_rvalid = 0; noc_rd_cen = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_grant", noc_rd_ready, DW'(1 << ((i + 1) % 4)));
      tick();
    end
    #1;
    chk("t3_full_ready", noc_rd_ready, 0);
    chk("t3_full_cen", ibuffer_cen, 0);
    ibuffer_rvalid = 1; #1;
    chk("t3_full_pop_ready", noc_rd_ready, 0);
    chk("t3_full_rvalid", noc_rd_rvalid, 4'b0010);
    tick();
    noc_rd_cen = 0; noc_rd_rready = 4'b1011; #1;
    chk("t3_bp_rvalid", noc_rd_rvalid, 4'b0100);
    chk("t3_bp_rready", ibuffer_rready, 0);
    tick();
    noc_rd_rready = 4'hF; #1;
    chk("t3_pop_rready", ibuffer_rready, 1);
    tick();

    // 4: drain with ch3, ch0 outstanding
    ibuffer_rvalid = 0; dma_read_start = 1; #1;
    tick();
    dma_read_start = 0; noc_rd_cen = 4'hF; #1;
    chk("t4_drain", phase, 3);
    chk("t4_no_grant", noc_rd_ready, 0);
    chk("t4_no_cen", ibuffer_cen, 0);
    ibuffer_rvalid = 1; #1;
    chk("t4_rvalid0", noc_rd_rvalid, 4'b1000);
    tick();
    #1;
    chk("t4_rvalid1", noc_rd_rvalid, 4'b0001);
    tick();
    ibuffer_rvalid = 0; noc_rd_cen = 0;
    tick();
    #1;
    chk("t4_dmawr", phase, 1);
    dma_wr_cen = 1; ibuffer_ready = 1; #1;
    chk("t4_dma_ready1", dma_wr_ready, 1);
    ibuffer_ready = 0; #1;
    chk("t4_dma_ready0", dma_wr_ready, 0);
    chk("t4_no_err", rsp_err, 0);

    // 5: orphan response
    dma_wr_cen = 0; ibuffer_ready = 1; dma_write_done = 1;
    tick();
    dma_write_done = 0; ibuffer_rvalid = 1; #1;
    chk("t5_phase", phase, 2);
    chk("t5_rready", ibuffer_rready, 1);
    chk("t5_rvalid", noc_rd_rvalid, 0);
    tick();
    ibuffer_rvalid = 0; #1;
    chk("t5_err", rsp_err, 1);
    tick(); tick(); #1;
    chk("t5_err_sticky", rsp_err, 1);

    // 6: reset with 3 outstanding (pointer at ch1)
    noc_rd_cen = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_grant", noc_rd_ready, DW'(1 << (i + 1)));
      tick();
    end
    ibuffer_rvalid = 1; rst_n = 0; #1;
    chk("t6_rst_phase", phase, 0);
    chk("t6_rst_ready", noc_rd_ready, 0);
    chk("t6_rst_rvalid", noc_rd_rvalid, 0);
    chk("t6_rst_cen", ibuffer_cen, 0);
    chk("t6_rst_err", rsp_err, 0);
    tick();
    rst_n = 1; ibuffer_rvalid = 0; noc_rd_cen = 0; dma_read_start = 1;
    tick();
    dma_read_start = 0; dma_write_done = 1;
    tick();
    dma_write_done = 0; ibuffer_rvalid = 1; #1;
    chk("t6_phase", phase, 2);
    chk("t6_empty_rvalid", noc_rd_rvalid, 0);
    chk("t6_empty_rready", ibuffer_rready, 1);
    ibuffer_rvalid = 0; noc_rd_cen = 4'hF; #1;
    chk("t6_ptr_reset", noc_rd_ready, 4'b0001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
